// File: rtl/mips_cpu_mem_controller.sv
// Avalon-MM master for the multicycle MIPS core: arbitrates fetch vs. load/store,
// runs one bus transaction at a time, and handles byte lanes and load extension.
module mips_cpu_mem_controller (
    input  logic        clk,
    input  logic        reset,
    input  logic        fetch_req,
    input  logic [31:0] fetch_addr,
    output logic        fetch_ack,
    output logic [31:0] fetch_rdata,
    input  logic        data_req,
    input  logic        data_we,
    input  logic [1:0]  data_size,
    input  logic        data_unsigned,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_ack,
    output logic [31:0] data_rdata,
    output logic        data_err,
    output logic        busy,
    output logic [31:0] mem_address,
    output logic        memread,
    output logic        memwrite,
    input  logic        waitrequest,
    output logic [31:0] memwritedata,
    output logic [3:0]  byteenable,
    input  logic [31:0] memreaddata
);
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t      state_reg, state_next;
    logic        last_data_reg, last_data_next;
    logic        grant_data_reg, grant_data_next;
    logic        we_reg, we_next;
    logic        is_unsigned_reg, is_unsigned_next;
    logic [1:0]  size_reg, size_next;
    logic [1:0]  offset_reg, offset_next;
    logic        fetch_ack_reg, fetch_ack_next;
    logic [31:0] fetch_rdata_reg, fetch_rdata_next;
    logic        data_ack_reg, data_ack_next;
    logic [31:0] data_rdata_reg, data_rdata_next;
    logic        data_err_reg, data_err_next;
    logic        busy_reg, busy_next;
    logic [31:0] mem_address_reg, mem_address_next;
    logic        memread_reg, memread_next;
    logic        memwrite_reg, memwrite_next;
    logic [31:0] memwritedata_reg, memwritedata_next;
    logic [3:0]  byteenable_reg, byteenable_next;

    logic        pick_data, pick_fetch, misaligned;
    logic [3:0]  req_be;
    logic [31:0] req_wdata, lane_data, load_data;
    logic        unused_bits;

    assign unused_bits = &{1'b0, fetch_addr[1:0]};

    // On a tie the port that did not win last time is granted.
    assign pick_data  = data_req && (!fetch_req || !last_data_reg);
    assign pick_fetch = fetch_req && !pick_data;
    assign misaligned = (data_size == 2'b11)
                     || (data_size == 2'b01 && data_addr[0])
                     || (data_size == 2'b10 && data_addr[1:0] != 2'b00);

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign req_wdata[8*gi +: 8] = (data_size == 2'b00) ? data_wdata[7:0]
                                        : (data_size == 2'b01) ? data_wdata[8*(gi%2) +: 8]
                                        : data_wdata[8*gi +: 8];
        end
    endgenerate

    always_comb begin
        case (data_size)
            2'b00:   req_be = 4'b0001 << data_addr[1:0];
            2'b01:   req_be = data_addr[1] ? 4'b1100 : 4'b0011;
            default: req_be = 4'b1111;
        endcase
    end

    // Right-justify the addressed lane(s), then extend.
    assign lane_data = memreaddata >> {offset_reg, 3'b000};
    always_comb begin
        case (size_reg)
            2'b00:   load_data = is_unsigned_reg ? {24'h0, lane_data[7:0]}
                                                 : {{24{lane_data[7]}}, lane_data[7:0]};
            2'b01:   load_data = is_unsigned_reg ? {16'h0, lane_data[15:0]}
                                                 : {{16{lane_data[15]}}, lane_data[15:0]};
            default: load_data = memreaddata;
        endcase
    end

    always_comb begin
        state_next        = state_reg;
        last_data_next    = last_data_reg;
        grant_data_next   = grant_data_reg;
        we_next           = we_reg;
        is_unsigned_next  = is_unsigned_reg;
        size_next         = size_reg;
        offset_next       = offset_reg;
        fetch_ack_next    = 1'b0;
        fetch_rdata_next  = fetch_rdata_reg;
        data_ack_next     = 1'b0;
        data_rdata_next   = data_rdata_reg;
        data_err_next     = 1'b0;
        mem_address_next  = mem_address_reg;
        memread_next      = memread_reg;
        memwrite_next     = memwrite_reg;
        memwritedata_next = memwritedata_reg;
        byteenable_next   = byteenable_reg;
        case (state_reg)
            IDLE: begin
                if (pick_data) begin
                    last_data_next   = 1'b1;
                    grant_data_next  = 1'b1;
                    we_next          = data_we;
                    is_unsigned_next = data_unsigned;
                    size_next        = data_size;
                    offset_next      = data_addr[1:0];
                    if (misaligned) begin
                        state_next      = RESP;
                        data_ack_next   = 1'b1;
                        data_err_next   = 1'b1;
                        data_rdata_next = 32'h0;
                    end else begin
                        state_next        = ACCESS;
                        mem_address_next  = {data_addr[31:2], 2'b00};
                        memread_next      = !data_we;
                        memwrite_next     = data_we;
                        byteenable_next   = req_be;
                        memwritedata_next = req_wdata;
                    end
                end else if (pick_fetch) begin
                    state_next       = ACCESS;
                    last_data_next   = 1'b0;
                    grant_data_next  = 1'b0;
                    we_next          = 1'b0;
                    mem_address_next = {fetch_addr[31:2], 2'b00};
                    memread_next     = 1'b1;
                    memwrite_next    = 1'b0;
                    byteenable_next  = 4'b1111;
                end
            end
            ACCESS: begin
                if (!waitrequest) begin
                    state_next    = RESP;
                    memread_next  = 1'b0;
                    memwrite_next = 1'b0;
                    if (grant_data_reg) begin
                        data_ack_next   = 1'b1;
                        data_rdata_next = we_reg ? 32'h0 : load_data;
                    end else begin
                        fetch_ack_next   = 1'b1;
                        fetch_rdata_next = memreaddata;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
        busy_next = (state_next != IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg        <= IDLE;
            last_data_reg    <= 1'b1;
            grant_data_reg   <= 1'b0;
            we_reg           <= 1'b0;
            is_unsigned_reg  <= 1'b0;
            size_reg         <= 2'b00;
            offset_reg       <= 2'b00;
            fetch_ack_reg    <= 1'b0;
            fetch_rdata_reg  <= 32'h0;
            data_ack_reg     <= 1'b0;
            data_rdata_reg   <= 32'h0;
            data_err_reg     <= 1'b0;
            busy_reg         <= 1'b0;
            mem_address_reg  <= 32'h0;
            memread_reg      <= 1'b0;
            memwrite_reg     <= 1'b0;
            memwritedata_reg <= 32'h0;
            byteenable_reg   <= 4'h0;
        end else begin
            state_reg        <= state_next;
            last_data_reg    <= last_data_next;
            grant_data_reg   <= grant_data_next;
            we_reg           <= we_next;
            is_unsigned_reg  <= is_unsigned_next;
            size_reg         <= size_next;
            offset_reg       <= offset_next;
            fetch_ack_reg    <= fetch_ack_next;
            fetch_rdata_reg  <= fetch_rdata_next;
            data_ack_reg     <= data_ack_next;
            data_rdata_reg   <= data_rdata_next;
            data_err_reg     <= data_err_next;
            busy_reg         <= busy_next;
            mem_address_reg  <= mem_address_next;
            memread_reg      <= memread_next;
            memwrite_reg     <= memwrite_next;
            memwritedata_reg <= memwritedata_next;
            byteenable_reg   <= byteenable_next;
        end
    end

    assign fetch_ack    = fetch_ack_reg;
    assign fetch_rdata  = fetch_rdata_reg;
    assign data_ack     = data_ack_reg;
    assign data_rdata   = data_rdata_reg;
    assign data_err     = data_err_reg;
    assign busy         = busy_reg;
    assign mem_address  = mem_address_reg;
    assign memread      = memread_reg;
    assign memwrite     = memwrite_reg;
    assign memwritedata = memwritedata_reg;
    assign byteenable   = byteenable_reg;
endmodule

// File: tb/tb_mips_cpu_mem_controller.sv
// Randomized bench: predicts arbitration order, bus cycles, ack timing and
// lane/extension results from the access rules with plain arithmetic.
module tb_mips_cpu_mem_controller;
    logic        clk = 1'b0;
    logic        reset;
    logic        fetch_req;
    logic [31:0] fetch_addr;
    logic        fetch_ack;
    logic [31:0] fetch_rdata;
    logic        data_req;
    logic        data_we;
    logic [1:0]  data_size;
    logic        data_unsigned;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_ack;
    logic [31:0] data_rdata;
    logic        data_err;
    logic        busy;
    logic [31:0] mem_address;
    logic        memread;
    logic        memwrite;
    logic        waitrequest;
    logic [31:0] memwritedata;
    logic [3:0]  byteenable;
    logic [31:0] memreaddata;

    mips_cpu_mem_controller dut (
        .clk(clk), .reset(reset),
        .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_ack(fetch_ack), .fetch_rdata(fetch_rdata),
        .data_req(data_req), .data_we(data_we), .data_size(data_size), .data_unsigned(data_unsigned),
        .data_addr(data_addr), .data_wdata(data_wdata), .data_ack(data_ack), .data_rdata(data_rdata),
        .data_err(data_err), .busy(busy), .mem_address(mem_address), .memread(memread),
        .memwrite(memwrite), .waitrequest(waitrequest), .memwritedata(memwritedata),
        .byteenable(byteenable), .memreaddata(memreaddata)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Expected transaction contents and arbitration history
    logic [31:0] f_addr_e, d_addr_e, d_wdata_e, rd_fixed;
    logic [1:0]  d_size_e;
    bit          d_we_e, d_uns_e, rd_fixed_en, last_data_m;
    int          nw_f, nw_d;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic bit is_bad(input logic [1:0] sz, input logic [31:0] addr);
        int unsigned a = addr;
        if (sz == 2'd3) return 1'b1;
        if (sz == 2'd1) return (a % 2) != 0;
        if (sz == 2'd2) return (a % 4) != 0;
        return 1'b0;
    endfunction

    function automatic logic [3:0] exp_be(input logic [1:0] sz, input logic [31:0] addr);
        int unsigned off = addr % 4;
        if (sz == 2'd0) return 4'(1 << off);
        if (sz == 2'd1) return 4'(3 << off);
        return 4'hF;
    endfunction

    function automatic logic [31:0] exp_wd(input logic [1:0] sz, input logic [31:0] w);
        if (sz == 2'd0) return (w & 32'hFF) * 32'h01010101;
        if (sz == 2'd1) return (w & 32'hFFFF) * 32'h00010001;
        return w;
    endfunction

    function automatic logic [31:0] exp_load(input logic [31:0] w, input logic [31:0] addr,
                                             input logic [1:0] sz, input bit uns);
        int unsigned off = addr % 4;
        int unsigned v;
        if (sz == 2'd0) begin
            v = (w >> (8 * off)) & 32'hFF;
            if (!uns && v >= 128) v = v + 32'hFFFFFF00;
        end else if (sz == 2'd1) begin
            v = (w >> (8 * off)) & 32'hFFFF;
            if (!uns && v >= 32768) v = v + 32'hFFFF0000;
        end else begin
            v = w;
        end
        return v;
    endfunction

    // Grant at edge g: strobe in cycles g+1..g+1+waits, ack in g+2+waits
    // (or g+1 for a rejected access); the next grant happens at ack+1.
    task automatic run_group(input bit do_f, input bit do_d);
        int order[$];
        int idx, g, cyc, exp_ack, nw;
        bit cur_d, err, strobe, wr;
        logic [31:0] rd_cap;
        @(negedge clk);
        check_val("idle_busy", busy, 0);
        check_val("idle_strobe", memread | memwrite, 0);
        if (do_f && do_d) begin
            if (last_data_m) begin order.push_back(0); order.push_back(1); end
            else begin order.push_back(1); order.push_back(0); end
        end else if (do_f) order.push_back(0);
        else if (do_d) order.push_back(1);
        fetch_req = do_f; fetch_addr = f_addr_e;
        data_req = do_d; data_we = d_we_e; data_size = d_size_e;
        data_unsigned = d_uns_e; data_addr = d_addr_e; data_wdata = d_wdata_e;
        idx = 0; g = 0; cyc = 0; rd_cap = 32'h0;
        while (idx < order.size()) begin
            @(negedge clk);
            cyc++;
            if (cyc > 40) begin
                check_val("timeout", 1, 0);
                break;
            end
            cur_d   = (order[idx] == 1);
            err     = cur_d && is_bad(d_size_e, d_addr_e);
            wr      = cur_d && d_we_e;
            nw      = cur_d ? nw_d : nw_f;
            exp_ack = g + (err ? 1 : 2 + nw);
            strobe  = !err && cyc >= g + 1 && cyc <= g + 1 + nw;
            check_val("busy", busy, (cyc >= g + 1 && cyc <= exp_ack));
            check_val("memread", memread, strobe && !wr);
            check_val("memwrite", memwrite, strobe && wr);
            check_val("fetch_ack", fetch_ack, cyc == exp_ack && !cur_d);
            check_val("data_ack", data_ack, cyc == exp_ack && cur_d);
            if (strobe) begin
                check_val("mem_address", mem_address, (cur_d ? d_addr_e : f_addr_e) & ~32'h3);
                check_val("byteenable", byteenable, cur_d ? exp_be(d_size_e, d_addr_e) : 4'hF);
                if (wr) check_val("memwritedata", memwritedata, exp_wd(d_size_e, d_wdata_e));
            end
            memreaddata = rd_fixed_en ? rd_fixed : $urandom;
            if (strobe) begin
                waitrequest = (cyc < g + 1 + nw);
                if (!waitrequest) rd_cap = memreaddata;
            end else begin
                waitrequest = 1'($urandom_range(0, 1));
            end
            if (cyc == exp_ack) begin
                if (cur_d) begin
                    check_val("data_err", data_err, err);
                    check_val("data_rdata", data_rdata,
                              (err || d_we_e) ? 32'h0 : exp_load(rd_cap, d_addr_e, d_size_e, d_uns_e));
                    $display("data  addr=%h size=%0d we=%0d uns=%0d waits=%0d err=%0d rdata=%h",
                             d_addr_e, d_size_e, d_we_e, d_uns_e, nw, err, data_rdata);
                    data_req = 1'b0;
                end else begin
                    check_val("fetch_rdata", fetch_rdata, rd_cap);
                    $display("fetch addr=%h waits=%0d rdata=%h", f_addr_e, nw, fetch_rdata);
                    fetch_req = 1'b0;
                end
                last_data_m = cur_d;
                idx++;
                g = cyc + 1;
            end
            // Request fields of a granted transaction must no longer matter
            if (idx < order.size() && cyc > g) begin
                if (order[idx] == 1) begin
                    data_addr = $urandom; data_wdata = $urandom; data_we = 1'($urandom);
                    data_size = 2'($urandom); data_unsigned = 1'($urandom);
                end else begin
                    fetch_addr = $urandom;
                end
            end
        end
        fetch_req = 1'b0;
        data_req  = 1'b0;
    endtask

    initial begin
        reset = 1'b1; fetch_req = 1'b0; fetch_addr = 32'h0; data_req = 1'b0; data_we = 1'b0;
        data_size = 2'b00; data_unsigned = 1'b0; data_addr = 32'h0; data_wdata = 32'h0;
        waitrequest = 1'b0; memreaddata = 32'h0; rd_fixed_en = 1'b0; rd_fixed = 32'h0;
        last_data_m = 1'b1;
        repeat (3) @(negedge clk);
        check_val("rst_outputs", {fetch_ack, data_ack, data_err, busy, memread, memwrite, byteenable}, 0);
        check_val("rst_fetch_rdata", fetch_rdata, 0);
        check_val("rst_data_rdata", data_rdata, 0);
        check_val("rst_address", mem_address, 0);
        check_val("rst_writedata", memwritedata, 0);
        reset = 1'b0;

        // Simultaneous requests right after reset: fetch, data, then fetch again
        f_addr_e = 32'h0040_0000; d_addr_e = 32'h0000_1000; d_size_e = 2'd2;
        d_we_e = 1'b0; d_uns_e = 1'b0; d_wdata_e = 32'h0; nw_f = 0; nw_d = 0;
        run_group(1, 1);
        run_group(1, 0);

        // Word fetch with two wait states
        rd_fixed_en = 1'b1; rd_fixed = 32'h2402_0005;
        f_addr_e = 32'hBFC0_0003; nw_f = 2;
        run_group(1, 0);

        // Signed and unsigned byte loads from lane 3
        rd_fixed = 32'h80FF_7F01;
        d_addr_e = 32'h0000_1003; d_size_e = 2'd0; d_we_e = 1'b0; d_uns_e = 1'b0; nw_d = 0;
        run_group(0, 1);
        d_uns_e = 1'b1;
        run_group(0, 1);
        rd_fixed_en = 1'b0;

        // Halfword store to the upper half with waits
        d_addr_e = 32'h0000_2002; d_size_e = 2'd1; d_we_e = 1'b1; d_wdata_e = 32'h1234_ABCD; nw_d = 2;
        run_group(0, 1);

        // Misaligned word load
        d_addr_e = 32'h0000_0006; d_size_e = 2'd2; d_we_e = 1'b0; nw_d = 0;
        run_group(0, 1);

        // Reset in the middle of a stalled fetch
        @(negedge clk);
        fetch_req = 1'b1; fetch_addr = 32'h0000_0100; waitrequest = 1'b1;
        @(negedge clk);
        check_val("rst_mid_strobe", memread, 1);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_val("rst_mid_memread", memread, 0);
        check_val("rst_mid_ack", fetch_ack, 0);
        check_val("rst_mid_busy", busy, 0);
        reset = 1'b0; fetch_req = 1'b0; waitrequest = 1'b0;
        last_data_m = 1'b1;
        @(negedge clk);
        check_val("rst_mid_no_late_ack", fetch_ack | data_ack, 0);
        f_addr_e = 32'h0000_0104; nw_f = 1;
        run_group(1, 0);

        // Randomized traffic
        for (int i = 0; i < 300; i++) begin
            bit df, dd;
            f_addr_e  = $urandom;
            d_addr_e  = $urandom;
            d_wdata_e = $urandom;
            d_size_e  = 2'($urandom_range(0, 3));
            d_we_e    = 1'($urandom);
            d_uns_e   = 1'($urandom);
            if ($urandom_range(0, 1) == 1) d_addr_e[1:0] = 2'b00;
            nw_f = $urandom_range(0, 3);
            nw_d = $urandom_range(0, 3);
            df = 1'($urandom);
            dd = 1'($urandom);
            if (!df && !dd) df = 1'b1;
            run_group(df, dd);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
